// File: rtl/passcoder_pkg.sv
// Shared types and constants for the passcode sequencer and its timer.
package passcoder_pkg;

  localparam int unsigned OPW_DEF    = 10;
  localparam int unsigned DW_DEF     = 5;
  localparam int unsigned NUM_DIGITS = 4;
  localparam int unsigned IDX_W      = 2;
  localparam int unsigned TMR_W      = 16;

  typedef enum logic [2:0] {
    IDLE,
    SETTLE,
    CAPTURE,
    SEND,
    GAP,
    DONE
  } state_t;

endpackage

// File: rtl/passcode_sequencer_seq_timer.sv
// Loadable down-counter with a registered zero flag; shared by the SETTLE and GAP waits.
module seq_timer
  import passcoder_pkg::*;
#(
  parameter int unsigned W = TMR_W
) (
  input  logic         clk,
  input  logic         rst_n,
  input  logic         load,
  input  logic [W-1:0] load_val,
  input  logic         dec,
  output logic         zero
);

  logic [W-1:0] count;

  // Load wins over decrement; the counter parks at zero.
  always_ff @(posedge clk) begin
    if (!rst_n) begin
      count <= '0;
      zero  <= 1'b1;
    end else if (load) begin
      count <= load_val;
      zero  <= (load_val == '0);
    end else if (dec && !zero) begin
      count <= count - W'(1);
      zero  <= (count == W'(1));
    end
  end

endmodule

// File: rtl/passcode_sequencer.sv
// Sequences one passcode: latch operands, let the ALU settle, capture four digits, stream them.
// Optional build macro PASSCODE_REPEAT_EN replays the digits forever until abort or reset.
module passcode_sequencer
  import passcoder_pkg::*;
#(
  parameter int unsigned OPW        = OPW_DEF,
  parameter int unsigned DW         = DW_DEF,
  parameter int unsigned SETTLE_CYC = 2,
  parameter int unsigned GAP_CYC    = 1000
) (
  input  logic                     clk,
  input  logic                     rst_n,
  input  logic                     start,
  input  logic                     abort,
  input  logic [OPW-1:0]           a_in,
  input  logic [OPW-1:0]           b_in,
  input  logic [2:0]               op_in,
  output logic [OPW-1:0]           alu_a,
  output logic [OPW-1:0]           alu_b,
  output logic [2:0]               alu_op,
  input  logic [NUM_DIGITS*DW-1:0] alu_dig,
  output logic [DW-1:0]            led_data,
  output logic                     led_valid,
  input  logic                     led_ready,
  output logic                     busy,
  output logic                     done,
  output logic [IDX_W-1:0]         digit_idx
);

  localparam int unsigned      BUF_W       = NUM_DIGITS * DW;
  localparam logic [TMR_W-1:0] SETTLE_LOAD = TMR_W'(SETTLE_CYC - 1);
  // Wraps when GAP_CYC is 0, but that path never loads it.
  localparam logic [TMR_W-1:0] GAP_LOAD    = TMR_W'(GAP_CYC - 1);
  localparam logic [IDX_W-1:0] LAST_IDX    = IDX_W'(NUM_DIGITS - 1);
`ifdef PASSCODE_REPEAT_EN
  localparam bit REPEAT = 1'b1;
`else
  localparam bit REPEAT = 1'b0;
`endif

  state_t             state, state_d;
  logic [BUF_W-1:0]   dig_buf, dig_buf_d;
  logic [IDX_W-1:0]   idx_d;
  logic [OPW-1:0]     alu_a_d, alu_b_d;
  logic [2:0]         alu_op_d;
  logic [DW-1:0]      led_data_d;
  logic               led_valid_d, busy_d, done_d;
  logic               tmr_load, tmr_dec, tmr_zero;
  logic [TMR_W-1:0]   tmr_val;

  seq_timer #(.W(TMR_W)) u_timer (
    .clk      (clk),
    .rst_n    (rst_n),
    .load     (tmr_load),
    .load_val (tmr_val),
    .dec      (tmr_dec),
    .zero     (tmr_zero)
  );

  // Next-state and next-output logic; abort pre-empts every active state.
  always_comb begin
    state_d   = state;
    dig_buf_d = dig_buf;
    idx_d     = digit_idx;
    alu_a_d   = alu_a;
    alu_b_d   = alu_b;
    alu_op_d  = alu_op;
    done_d    = 1'b0;
    tmr_load  = 1'b0;
    tmr_dec   = 1'b0;
    tmr_val   = SETTLE_LOAD;

    if (state != IDLE && abort) begin
      state_d = IDLE;
    end else begin
      case (state)
        IDLE: begin
          if (start && !abort) begin
            alu_a_d  = a_in;
            alu_b_d  = b_in;
            alu_op_d = op_in;
            tmr_load = 1'b1;
            tmr_val  = SETTLE_LOAD;
            state_d  = SETTLE;
          end
        end
        SETTLE: begin
          if (tmr_zero) state_d = CAPTURE;
          else          tmr_dec = 1'b1;
        end
        CAPTURE: begin
          dig_buf_d = alu_dig;
          idx_d     = '0;
          state_d   = SEND;
        end
        SEND: begin
          if (led_ready) begin
            done_d = (digit_idx == LAST_IDX);
            // Wraps back to digit 0 after the last one, which is what replay needs.
            idx_d  = digit_idx + IDX_W'(1);
            if (!REPEAT && digit_idx == LAST_IDX) begin
              state_d = DONE;
            end else if (GAP_CYC == 0) begin
              state_d = SEND;
            end else begin
              tmr_load = 1'b1;
              tmr_val  = GAP_LOAD;
              state_d  = GAP;
            end
          end
        end
        GAP: begin
          if (tmr_zero) state_d = SEND;
          else          tmr_dec = 1'b1;
        end
        DONE:    state_d = IDLE;
        default: state_d = IDLE;
      endcase
    end

    led_valid_d = (state_d == SEND);
    busy_d      = (state_d != IDLE);
    led_data_d  = dig_buf_d[32'(idx_d) * DW +: DW];
  end

  always_ff @(posedge clk) begin
    if (!rst_n) begin
      state     <= IDLE;
      dig_buf   <= '0;
      alu_a     <= '0;
      alu_b     <= '0;
      alu_op    <= '0;
      led_data  <= '0;
      led_valid <= 1'b0;
      busy      <= 1'b0;
      done      <= 1'b0;
      digit_idx <= '0;
    end else begin
      state     <= state_d;
      dig_buf   <= dig_buf_d;
      alu_a     <= alu_a_d;
      alu_b     <= alu_b_d;
      alu_op    <= alu_op_d;
      led_data  <= led_data_d;
      led_valid <= led_valid_d;
      busy      <= busy_d;
      done      <= done_d;
      digit_idx <= idx_d;
    end
  end

endmodule
